// File: rtl/pe_id_scan_loader.sv
// pe_id_scan_loader: snapshots the PE-array ID map on start and streams it
// one ID per beat over a valid/ready config bus. Per bus the order is the
// PE_H row YIDs followed by the PE_H*PE_W XIDs in row-major order. Buses go
// filter, ifmap, ipsum, opsum, and a single LN_config beat closes the stream.
// Optional feature macro: ID_SKIP_DISABLED_EN. When it is defined, all-ones
// (disabled) IDs are skipped in the same cycle, so no bubble is inserted.
module pe_id_scan_loader #(
  parameter int PE_H  = 6,
  parameter int PE_W  = 8,
  parameter int XID_W = 5,
  parameter int YID_W = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PE_H*PE_W*XID_W-1:0]  filter_XID,
  input  logic [PE_H*PE_W*XID_W-1:0]  ifmap_XID,
  input  logic [PE_H*PE_W*XID_W-1:0]  ipsum_XID,
  input  logic [PE_H*PE_W*XID_W-1:0]  opsum_XID,
  input  logic [PE_H*YID_W-1:0]       filter_YID,
  input  logic [PE_H*YID_W-1:0]       ifmap_YID,
  input  logic [PE_H*YID_W-1:0]       ipsum_YID,
  input  logic [PE_H*YID_W-1:0]       opsum_YID,
  input  logic [4:0]                  LN_config,
  output logic                        cfg_valid,
  input  logic                        cfg_ready,
  output logic [1:0]                  cfg_bus,
  output logic [1:0]                  cfg_kind,
  output logic [2:0]                  cfg_row,
  output logic [2:0]                  cfg_col,
  output logic [4:0]                  cfg_data,
  output logic                        busy,
  output logic                        done
);

  localparam int XW = PE_H*PE_W*XID_W;
  localparam int YW = PE_H*YID_W;
  localparam int NB = PE_H + PE_H*PE_W;   // ID beats per bus
  localparam int NT = 4*NB;               // ID beats in total; index NT is the LN beat
  localparam int IW = $clog2(NT+1);

  typedef enum logic [2:0] {S_IDLE, S_SEND_Y, S_SEND_X, S_SEND_LN, S_DONE} state_t;

  state_t          r_state;
  logic [XW-1:0]   r_sx [4];
  logic [YW-1:0]   r_sy [4];
  logic [4:0]      r_ln;
  logic [IW-1:0]   r_idx;

  logic [XW-1:0]   w_sx [4];
  logic [YW-1:0]   w_sy [4];
  logic [4:0]      w_ln;
  logic [IW-1:0]   w_from;
  logic            w_accept;
  logic            w_load;
  logic            w_found;
  logic            w_nky;
  logic [IW-1:0]   w_nidx;
  logic [1:0]      w_nbus;
  logic [2:0]      w_nrow;
  logic [2:0]      w_ncol;
  logic [4:0]      w_ndata;

  assign w_accept = cfg_valid & cfg_ready;
  assign w_load   = ((r_state == S_IDLE) & start) |
                    (((r_state == S_SEND_Y) | (r_state == S_SEND_X)) & w_accept);
  assign w_from   = (r_state == S_IDLE) ? '0 : r_idx + IW'(1);

  // ID source: live inputs while capturing in IDLE, frozen snapshot otherwise
  always_comb begin
    if (r_state == S_IDLE) begin
      w_sx[0] = filter_XID;  w_sx[1] = ifmap_XID;
      w_sx[2] = ipsum_XID;   w_sx[3] = opsum_XID;
      w_sy[0] = filter_YID;  w_sy[1] = ifmap_YID;
      w_sy[2] = ipsum_YID;   w_sy[3] = opsum_YID;
      w_ln    = LN_config;
    end else begin
      for (int b = 0; b < 4; b++) begin
        w_sx[b] = r_sx[b];
        w_sy[b] = r_sy[b];
      end
      w_ln = r_ln;
    end
  end

  // Find the first emitted beat at or after w_from; none found means the LN beat is next
  always_comb begin : p_search
    logic v_en;
    int   v_idx;
    v_en    = 1'b1;
    v_idx   = 0;
    w_found = 1'b0;
    w_nky   = 1'b0;
    w_nidx  = IW'(NT);
    w_nbus  = '0;
    w_nrow  = '0;
    w_ncol  = '0;
    w_ndata = '0;
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < PE_H; r++) begin
        v_idx = b*NB + r;
        v_en  = 1'b1;
`ifdef ID_SKIP_DISABLED_EN
        v_en  = ~&w_sy[b][r*YID_W +: YID_W];
`endif
        if (!w_found && v_en && v_idx >= int'(w_from)) begin
          w_found = 1'b1;
          w_nky   = 1'b1;
          w_nidx  = IW'(v_idx);
          w_nbus  = 2'(b);
          w_nrow  = 3'(r);
          w_ncol  = '0;
          w_ndata = 5'(w_sy[b][r*YID_W +: YID_W]);
        end
      end
      for (int r = 0; r < PE_H; r++) begin
        for (int c = 0; c < PE_W; c++) begin
          v_idx = b*NB + PE_H + r*PE_W + c;
          v_en  = 1'b1;
`ifdef ID_SKIP_DISABLED_EN
          v_en  = ~&w_sx[b][(r*PE_W+c)*XID_W +: XID_W];
`endif
          if (!w_found && v_en && v_idx >= int'(w_from)) begin
            w_found = 1'b1;
            w_nky   = 1'b0;
            w_nidx  = IW'(v_idx);
            w_nbus  = 2'(b);
            w_nrow  = 3'(r);
            w_ncol  = 3'(c);
            w_ndata = 5'(w_sx[b][(r*PE_W+c)*XID_W +: XID_W]);
          end
        end
      end
    end
  end

  // Transfer FSM with registered beat fields and snapshot capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_ln      <= '0;
      for (int b = 0; b < 4; b++) begin
        r_sx[b] <= '0;
        r_sy[b] <= '0;
      end
      cfg_valid <= 1'b0;
      cfg_bus   <= '0;
      cfg_kind  <= '0;
      cfg_row   <= '0;
      cfg_col   <= '0;
      cfg_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (w_load) begin
      if (r_state == S_IDLE) begin
        r_sx[0] <= filter_XID;  r_sx[1] <= ifmap_XID;
        r_sx[2] <= ipsum_XID;   r_sx[3] <= opsum_XID;
        r_sy[0] <= filter_YID;  r_sy[1] <= ifmap_YID;
        r_sy[2] <= ipsum_YID;   r_sy[3] <= opsum_YID;
        r_ln    <= LN_config;
      end
      cfg_valid <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      r_idx     <= w_nidx;
      if (w_found) begin
        r_state  <= w_nky ? S_SEND_Y : S_SEND_X;
        cfg_bus  <= w_nbus;
        cfg_kind <= w_nky ? 2'd0 : 2'd1;
        cfg_row  <= w_nrow;
        cfg_col  <= w_ncol;
        cfg_data <= w_ndata;
      end else begin
        r_state  <= S_SEND_LN;
        cfg_bus  <= '0;
        cfg_kind <= 2'd2;
        cfg_row  <= '0;
        cfg_col  <= '0;
        cfg_data <= w_ln;
      end
    end else begin
      case (r_state)
        S_SEND_LN: begin
          if (w_accept) begin
            r_state   <= S_DONE;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            cfg_bus   <= '0;
            cfg_kind  <= '0;
            cfg_row   <= '0;
            cfg_col   <= '0;
            cfg_data  <= '0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule
